// File: rtl/tcdm_pkg.sv
// Shared types and helpers for the TCDM bank return path.
package tcdm_pkg;

   localparam int unsigned MaxBankLatency = 4;
   // Widest master index carried in flight; a bank adapter uses the low idx_width(NumIn) bits.
   localparam int unsigned MetaIdxW = 16;

   typedef struct packed {
      logic                valid;
      logic                wen;
      logic [MetaIdxW-1:0] idx;
   } tcdm_meta_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/tcdm_resp_pipe.sv
// Latency-matched shift register carrying per-access metadata from the
// SRAM request cycle to the cycle its read data or write ack is due.
module tcdm_resp_pipe
   import tcdm_pkg::*;
#(
   parameter int unsigned Depth = 1
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  tcdm_meta_t meta_i,
   output tcdm_meta_t tail_o,
   output logic       busy_o
);

   tcdm_meta_t stage_q [Depth];

   // NOTE: the stage array is only a few bits per entry, so every entry is reset;
   // a dropped valid bit must never resurface after reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < Depth; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= meta_i;
         for (int i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   always_comb begin
      busy_o = 1'b0;
      for (int i = 0; i < Depth; i++) busy_o = busy_o | stage_q[i].valid;
   end

   assign tail_o = stage_q[Depth-1];

endmodule

// File: rtl/tcdm_bank_adapter.sv
// Per-bank adapter between the RR arbitration tree and one SRAM bank: request
// pass-through plus one-hot response routing. Define TCDM_BANK_ADAPTER_RESP_REG_EN to register the response outputs.
module tcdm_bank_adapter
   import tcdm_pkg::*;
#(
   parameter int unsigned  NumIn       = 32,
   parameter int unsigned  DataWidth   = 32,
   parameter int unsigned  AddrWidth   = 10,
   parameter int unsigned  BankLatency = 1,
   parameter bit           WriteResp   = 1'b1,
   localparam int unsigned IdxW        = idx_width(NumIn)
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   req_i,
   output logic                   gnt_o,
   input  logic [IdxW-1:0]        idx_i,
   input  logic                   wen_i,
   input  logic [AddrWidth-1:0]   add_i,
   input  logic [DataWidth-1:0]   wdata_i,
   input  logic [DataWidth/8-1:0] be_i,
   output logic                   bank_req_o,
   output logic                   bank_we_o,
   output logic [AddrWidth-1:0]   bank_add_o,
   output logic [DataWidth-1:0]   bank_wdata_o,
   output logic [DataWidth/8-1:0] bank_be_o,
   input  logic                   bank_gnt_i,
   input  logic [DataWidth-1:0]   bank_rdata_i,
   output logic [NumIn-1:0]       rvalid_o,
   output logic [DataWidth-1:0]   rdata_o,
   output logic [IdxW-1:0]        ridx_o,
   output logic                   busy_o
);

   if (BankLatency < 1 || BankLatency > MaxBankLatency) begin : g_bad_latency
      $error("tcdm_bank_adapter: BankLatency %0d outside 1..%0d", BankLatency, MaxBankLatency);
   end
   if (IdxW > MetaIdxW) begin : g_bad_idx
      $error("tcdm_bank_adapter: NumIn %0d needs a wider in-flight index", NumIn);
   end

   localparam int unsigned CntW = $clog2(BankLatency + 2);

   logic            handshake;
   tcdm_meta_t      push_meta;
   tcdm_meta_t      tail;
   logic            pipe_busy;
   logic            tail_idx_ok;
   logic [CntW-1:0] inflight_q;

   logic [NumIn-1:0]     rvalid_d;
   logic [DataWidth-1:0] rdata_d;
   logic [IdxW-1:0]      ridx_d;

   // The arbiter advances its pointer on gnt_o, so a stalled bank holds the arbiter too.
   assign handshake    = req_i & bank_gnt_i;
   assign gnt_o        = handshake;
   assign bank_req_o   = req_i;
   assign bank_we_o    = wen_i;
   assign bank_add_o   = add_i;
   assign bank_wdata_o = wdata_i;
   assign bank_be_o    = be_i;

   always_comb begin
      push_meta       = '0;
      push_meta.valid = handshake;
      push_meta.wen   = wen_i;
      push_meta.idx   = MetaIdxW'(idx_i);
   end

   tcdm_resp_pipe #(
      .Depth (BankLatency)
   ) i_resp_pipe (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .meta_i (push_meta),
      .tail_o (tail),
      .busy_o (pipe_busy)
   );

   assign tail_idx_ok = tail.idx < MetaIdxW'(NumIn);

   // NOTE: every output of this block gets a default first, so no path leaves
   // a value held over and no latch is inferred.
   always_comb begin
      rvalid_d = '0;
      rdata_d  = '0;
      ridx_d   = '0;
      if (tail.valid && tail_idx_ok && (!tail.wen || WriteResp)) begin
         rvalid_d[tail.idx[IdxW-1:0]] = 1'b1;
         ridx_d                       = tail.idx[IdxW-1:0];
         if (!tail.wen) rdata_d = bank_rdata_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         inflight_q <= '0;
      end else if (handshake && !tail.valid) begin
         inflight_q <= inflight_q + CntW'(1);
      end else if (!handshake && tail.valid) begin
         inflight_q <= inflight_q - CntW'(1);
      end
   end

   inflight_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
      inflight_q <= CntW'(BankLatency));

   idx_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
      handshake |-> (32'(idx_i) < NumIn));

`ifdef TCDM_BANK_ADAPTER_RESP_REG_EN
   logic [NumIn-1:0]     rvalid_q;
   logic [DataWidth-1:0] rdata_q;
   logic [IdxW-1:0]      ridx_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rvalid_q <= '0;
         rdata_q  <= '0;
         ridx_q   <= '0;
      end else begin
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         ridx_q   <= ridx_d;
      end
   end

   assign rvalid_o = rvalid_q;
   assign rdata_o  = rdata_q;
   assign ridx_o   = ridx_q;
   assign busy_o   = pipe_busy | (|rvalid_q);
`else
   assign rvalid_o = rvalid_d;
   assign rdata_o  = rdata_d;
   assign ridx_o   = ridx_d;
   assign busy_o   = pipe_busy;
`endif

endmodule

// File: doc/tcdm_bank_adapter.md
Name: tcdm_bank_adapter

Overview:
- Sits directly downstream of the round-robin arbitration tree, one instance per TCDM bank.
- Takes the single arbitrated request plus winning master index, drives the SRAM bank port, and tracks in-flight accesses in a latency-matched pipeline.
- Routes each read response or write ack back to the originating master as a one-hot valid.
- Provides the return path the arbiter lacks.

Parameters:
- NumIn, 32, number of masters arbitrated in front of this bank; index width IdxW = max(1, $clog2(NumIn)).
- DataWidth, 32, bank word width.
- AddrWidth, 10, bank-local word address width.
- BankLatency, 1, SRAM read latency in cycles; legal range 1..4; elaboration error otherwise.
- WriteResp, 1'b1, 1: writes return an ack (rvalid, rdata = 0); 0: writes return nothing.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  arbitrated request valid
- gnt_o  out  1  grant back to arbiter (its gnt_i)
- idx_i  in  IdxW  winning master index
- wen_i  in  1  1 = write, 0 = read
- add_i  in  AddrWidth  word address
- wdata_i  in  DataWidth  write data
- be_i  in  DataWidth/8  byte enables
- bank_req_o  out  1  SRAM request
- bank_we_o  out  1  SRAM write enable
- bank_add_o  out  AddrWidth  SRAM address
- bank_wdata_o  out  DataWidth  SRAM write data
- bank_be_o  out  DataWidth/8  SRAM byte enables
- bank_gnt_i  in  1  SRAM accepts (0 during BIST/refresh stall)
- bank_rdata_i  in  DataWidth  SRAM read data, valid BankLatency cycles after an accepted read
- rvalid_o  out  NumIn  one-hot response valid per master
- rdata_o  out  DataWidth  response data, shared across masters
- ridx_o  out  IdxW  index of the responding master
- busy_o  out  1  any access in flight

Behaviour:
- Request path is combinational:
  - bank_req_o = req_i.
  - bank_we_o, bank_add_o, bank_wdata_o and bank_be_o pass straight through.
  - gnt_o = req_i & bank_gnt_i.
- Handshake fires when req_i & bank_gnt_i. The arbiter advances its RR pointer only on that cycle.
- On a handshake, push {valid=1, wen_i, idx_i} into stage 0 of a BankLatency-deep shift pipeline. Otherwise push valid=0. The pipeline shifts every cycle with no backpressure; masters always accept responses.
- Tail stage (entry accepted in cycle t, seen in cycle t+BankLatency):
  - Read: rvalid_o[idx] = 1, rdata_o = bank_rdata_i, ridx_o = idx.
  - Write with WriteResp=1: rvalid_o[idx] = 1, rdata_o = 0.
  - Write with WriteResp=0: rvalid_o = 0.
  - Tail invalid: rvalid_o = 0, rdata_o = 0, ridx_o = 0.
- Throughput is one access per cycle. Back-to-back accesses from different masters return in order, one per cycle.
- busy_o = OR of all pipeline valid bits (in-flight count > 0).
- An in-flight counter, width $clog2(BankLatency+2), increments on a handshake and decrements on tail valid. Both events in the same cycle leave it unchanged. An overflow assertion fires if it exceeds BankLatency.
- Reset: pipeline valids 0, counter 0, rvalid_o 0, rdata_o 0, ridx_o 0, busy_o 0.
- Reset mid-operation: in-flight responses are dropped silently. No rvalid is emitted after deassertion until a new handshake.
- bank_gnt_i = 0 with req_i = 1: gnt_o = 0, nothing pushed, and the arbiter holds its state.
- Index boundary: idx_i >= NumIn (non-power-of-two NumIn) is flagged by an assertion and produces rvalid_o = 0.

Optional Feature:
- Macro: TCDM_BANK_ADAPTER_RESP_REG_EN.
- Defined: rvalid_o, rdata_o and ridx_o are registered with reset value 0. Response latency becomes BankLatency+1. busy_o also covers the output register.
- Undefined: the outputs are driven combinationally from the tail stage and bank_rdata_i, with latency BankLatency.

Decomposition:
- Shared package tcdm_pkg holds:
  - typedef tcdm_meta_t {logic valid; logic wen; logic [IdxW-1:0] idx;}, parameterised via localparam.
  - constant MaxBankLatency = 4.
  - function idx_width(n) returning max(1, $clog2(n)).
- One natural sub-module: tcdm_resp_pipe, the parameterised BankLatency-deep meta shift register with reset and tail output.
- The top level keeps the request pass-through, the one-hot decode and the optional output register.

Test Plan:
- Read, BankLatency=1: read, idx_i=5, add_i=0x12; SRAM returns 0xCAFEF00D in cycle t+1 -> gnt_o=1 at t; at t+1 rvalid_o=32'h0000_0020, rdata_o=0xCAFEF00D, ridx_o=5.
- Streaming, BankLatency=2: reads from idx 0, 1, 2 in consecutive cycles -> rvalid_o one-hot 0x1, 0x2, 0x4 on cycles t+2, t+3, t+4; busy_o high from t+1 through t+4.
- Write ack: write, idx 3, WriteResp=1 -> rvalid_o=0x8, rdata_o=0 after BankLatency. Rerun with WriteResp=0 -> rvalid_o stays 0.
- Bank stall: req_i=1, bank_gnt_i=0 for 3 cycles, then 1 -> gnt_o=0 for 3 cycles, a single push, exactly one response.
- Reset mid-flight: BankLatency=3, two reads in flight, rst_ni pulsed low -> all outputs 0; no rvalid in the 4 cycles after release.
- With TCDM_BANK_ADAPTER_RESP_REG_EN: the first scenario repeated -> response appears at t+2 with identical values.
